// File: rtl/combi_pkg.sv
// combi_pkg: shared state encoding and register-index width for the hazard sequencer
package combi_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {HZ_BOOT, HZ_RUN, HZ_MUL_BUSY} hz_state_t;
endpackage

// File: rtl/hz_down_counter.sv
// hz_down_counter: loadable down-counter shared by boot hold-off and multiply occupancy
module hz_down_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_is_one,
  output logic         o_is_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk) r_cnt <= i_load ? i_val : (i_dec && r_cnt != '0) ? r_cnt - W'(1) : r_cnt;
  assign o_is_one  = r_cnt == W'(1);
  assign o_is_zero = r_cnt == '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the combined ARM/RISC-V five-stage pipeline
// Registered BOOT/RUN/MUL_BUSY state; stall and flush outputs decoded combinationally from it.
module hazard_ctrl import combi_pkg::*; #(
  parameter int BOOT_CYCLES = 2,
  parameter int MUL_LAT     = 3,
  parameter int REG_W       = combi_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             armD,
  input  logic             armE,
  input  logic             armM,
  input  logic             armW,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdE,
  input  logic             RegWriteE,
  input  logic             LoadE,
  input  logic [1:0]       BranchTakenE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             MulStartE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             BubbleM,
  output logic             MulDoneE,
  output logic [1:0]       StateO
);
  localparam int   CMAX      = BOOT_CYCLES > MUL_LAT ? BOOT_CYCLES : MUL_LAT;
  localparam int   CW        = $clog2(CMAX + 1);
  localparam logic MUL_MULTI = MUL_LAT > 1;
  function automatic logic f_load_use(input logic load, input logic wr, input logic arm,
                                      input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                                      input logic [REG_W-1:0] rs2);
    return load & wr & (arm | rd != '0) & (rd == rs1 | rd == rs2);
  endfunction
  function automatic logic f_pend(input logic ad, input logic pd, input logic ae, input logic pe,
                                  input logic am, input logic pm);
    return (ad & pd) | (ae & pe) | (am & pm);
  endfunction
  hz_state_t     r_state, w_next;
  logic          w_redir, w_mul, w_lu, w_pend, w_cnt_end, w_is_one, w_is_zero;
  logic          w_load, w_dec;
  logic [CW-1:0] w_load_val;
  logic          w_unused;
  // A PC write already in W needs no action: fetch simply picks up ResultW.
  assign w_unused   = armW ^ PCSrcW;
  assign w_redir    = BranchTakenE != 2'b00;
  assign w_mul      = MUL_MULTI & MulStartE & ~w_redir;
  assign w_lu       = f_load_use(LoadE, RegWriteE, armE, RdE, Rs1D, Rs2D);
  assign w_pend     = f_pend(armD, PCSrcD, armE, PCSrcE, armM, PCSrcM);
  assign w_cnt_end  = w_is_one | w_is_zero;
  assign w_load     = rst | (r_state == HZ_RUN & w_mul);
  assign w_load_val = rst ? CW'(BOOT_CYCLES) : CW'(MUL_LAT - 1);
  assign w_dec      = r_state == HZ_BOOT | r_state == HZ_MUL_BUSY;
  assign StateO     = r_state;
  hz_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .i_load   (w_load),
    .i_val    (w_load_val),
    .i_dec    (w_dec),
    .o_is_one (w_is_one),
    .o_is_zero(w_is_zero)
  );
  always_comb begin
    w_next = HZ_BOOT;
    if (r_state == HZ_BOOT) w_next = w_cnt_end ? HZ_RUN : HZ_BOOT;
    else if (r_state == HZ_MUL_BUSY) w_next = w_cnt_end ? HZ_RUN : HZ_MUL_BUSY;
    else if (r_state == HZ_RUN) w_next = w_mul ? HZ_MUL_BUSY : HZ_RUN;
  end
  always_ff @(posedge clk) r_state <= rst ? HZ_BOOT : w_next;
  always_comb begin
    {StallF, StallD, FlushD, StallE, FlushE, BubbleM, MulDoneE} = '0;
    if (rst || r_state == HZ_BOOT) {StallF, FlushD, FlushE} = 3'b111;
    else if (r_state == HZ_MUL_BUSY) begin
      if (w_cnt_end) MulDoneE = 1'b1;
      else {StallF, StallD, StallE, BubbleM} = 4'hf;
    end else if (r_state == HZ_RUN) begin
      MulDoneE = MUL_MULTI ? 1'b0 : MulStartE & ~w_redir;
      // Load-use outranks pend so D is held rather than flushed when both apply.
      if (w_redir) {FlushD, FlushE} = 2'b11;
      else if (w_mul) {StallF, StallD, StallE, BubbleM} = 4'hf;
      else if (w_lu) {StallF, StallD, FlushE} = 3'b111;
      else if (w_pend) {StallF, FlushD} = 2'b11;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of boot, load-use, redirect, ARM PC-write, multiply and reset abort
module tb_hazard_ctrl;
  localparam logic [6:0] ZERO  = 7'b0000000;
  localparam logic [6:0] BOOTV = 7'b1010100;
  localparam logic [6:0] LU    = 7'b1100100;
  localparam logic [6:0] REDIR = 7'b0010100;
  localparam logic [6:0] MULS  = 7'b1101010;
  localparam logic [6:0] DONE  = 7'b0000001;
  localparam logic [6:0] PEND  = 7'b1010000;
  logic       clk, rst;
  logic       armD, armE, armM, armW;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic       RegWriteE, LoadE;
  logic [1:0] BranchTakenE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, MulStartE;
  logic       StallF, StallD, FlushD, StallE, FlushE, BubbleM, MulDoneE;
  logic [1:0] StateO;
  int total = 0;
  int bad = 0;
  hazard_ctrl #(.BOOT_CYCLES(2), .MUL_LAT(3), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .armD(armD), .armE(armE), .armM(armM), .armW(armW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE),
    .BranchTakenE(BranchTakenE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .MulStartE(MulStartE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .StallE(StallE), .FlushE(FlushE), .BubbleM(BubbleM),
    .MulDoneE(MulDoneE), .StateO(StateO)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_o(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {StallF, StallD, FlushD, StallE, FlushE, BubbleM, MulDoneE};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s outs got=%b want=%b", tag, obs, exp);
    end
  endtask
  task automatic chk_s(input string tag, input logic [1:0] exp);
    total++;
    assert (StateO === exp) else begin
      bad++;
      $error("FAIL %s state got=%0d want=%0d", tag, StateO, exp);
    end
  endtask
  task automatic clear_in;
    {armD, armE, armM, armW, RegWriteE, LoadE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, MulStartE} = '0;
    {Rs1D, Rs2D, RdE} = '0;
    BranchTakenE = 2'b00;
  endtask
  initial begin
    clear_in();
    rst = 1'b1;
    chk_o("in_reset", BOOTV);
    tick();
    tick();
    rst = 1'b0;
    chk_o("boot1", BOOTV); chk_s("boot1", 2'd0);
    tick();
    chk_o("boot2", BOOTV); chk_s("boot2", 2'd0);
    tick();
    chk_o("run_idle", ZERO); chk_s("run_idle", 2'd1);
    LoadE = 1; RegWriteE = 1; RdE = 5; Rs2D = 5; Rs1D = 3;
    chk_o("load_use", LU);
    tick();
    LoadE = 0; RegWriteE = 0;
    chk_o("after_bubble", ZERO);
    LoadE = 1; RegWriteE = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
    chk_o("rv_x0_no_stall", ZERO);
    armE = 1;
    chk_o("arm_r0_stalls", LU);
    armE = 0; RdE = 7; Rs1D = 7;
    BranchTakenE = 2'b01;
    chk_o("redir_over_lu", REDIR);
    BranchTakenE = 2'b10;
    chk_o("redir_alu", REDIR);
    BranchTakenE = 2'b00; armD = 1; PCSrcD = 1;
    chk_o("lu_and_pend", LU);
    tick();
    clear_in();
    armD = 1; PCSrcD = 1;
    chk_o("pend_d", PEND);
    tick();
    armD = 0; PCSrcD = 0; armE = 1; PCSrcE = 1;
    chk_o("pend_e", PEND);
    tick();
    armE = 0; PCSrcE = 0; armM = 1; PCSrcM = 1;
    chk_o("pend_m", PEND);
    tick();
    armM = 0; PCSrcM = 0; armW = 1; PCSrcW = 1;
    chk_o("pcw_only", ZERO);
    tick();
    clear_in();
    MulStartE = 1;
    chk_o("mul_c1", MULS); chk_s("mul_c1", 2'd1);
    tick();
    MulStartE = 0; BranchTakenE = 2'b01;
    chk_o("mul_c2", MULS); chk_s("mul_c2", 2'd2);
    tick();
    chk_o("mul_c3", DONE); chk_s("mul_c3", 2'd2);
    tick();
    BranchTakenE = 2'b00;
    chk_o("mul_after", ZERO); chk_s("mul_after", 2'd1);
    MulStartE = 1;
    tick();
    MulStartE = 0;
    chk_o("abort_busy", MULS); chk_s("abort_busy", 2'd2);
    rst = 1'b1;
    chk_o("abort_rst", BOOTV);
    tick();
    chk_o("abort_boot", BOOTV); chk_s("abort_boot", 2'd0);
    rst = 1'b0;
    tick();
    chk_o("reboot2", BOOTV); chk_s("reboot2", 2'd0);
    tick();
    chk_o("rerun", ZERO); chk_s("rerun", 2'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
